wb_wait_mem: RTL and testbench

Parametrised Wishbone slave combining a byte-writable word memory, a programmable wait-state generator, and a control/status register (CSR) window with a free-running cycle counter. It sits in the user project area behind the management-SoC Wishbone bus and succeeds the fixed-delay, fixed-width user-project slave. Wait states, memory depth and counter width are configurable, and it adds master-abort handling and a wrap interrupt.

---
 rtl/wb_wait_mem_pkg.sv | 19 +
 rtl/wb_wait_mem_ram.sv | 28 ++
 rtl/wb_wait_mem.sv | 142 ++++++++++++++
 tb/tb_wb_wait_mem.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_wait_mem_pkg.sv
// Shared constants for wb_wait_mem: FSM encoding, CSR word map and CTRL bit layout.
package wb_wait_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_COUNT  = 2'd1;
  localparam logic [1:0] CSR_STATUS = 2'd2;
  localparam logic [1:0] CSR_XFERS  = 2'd3;

  localparam int CTRL_EN_BIT  = 16;
  localparam int CTRL_CLR_BIT = 17;
  localparam int CSR_SEL_BIT  = 19;

endpackage

// File: rtl/wb_wait_mem_ram.sv
// Single-port DEPTHx32 RAM with per-byte write lanes and a registered read port.
module wb_wait_mem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    sel,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (sel[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_wait_mem.sv
// Wishbone slave: byte-writable memory, programmable wait states, CSR window with cycle counter.
//   state | meaning
//   IDLE  | waiting for a decoded hit; latches delay into wcnt
//   WAIT  | wcnt counting down; bus drop aborts with no side effects
//   ACK   | one-cycle acknowledge, then back to IDLE
module wb_wait_mem
  import wb_wait_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter logic [31:0] BASE_MASK = 32'hFFF0_0000,
  parameter int          DEPTH     = 1024,
  parameter int          DELAY_W   = 8,
  parameter int          RST_DELAY = 10,
  parameter int          CNT_W     = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [CNT_W-1:0] count_o,
  output logic             irq_o
);

  localparam int AW = $clog2(DEPTH);

  state_e             state;
  logic [DELAY_W-1:0] wcnt;
  logic [DELAY_W-1:0] delay;
  logic               cnt_en;
  logic [CNT_W-1:0]   count;
  logic               wrap;
  logic [31:0]        xfers;
  logic               rd_mem_q;
  logic [31:0]        csr_q;
  logic [31:0]        csr_rdata;
  logic [31:0]        ctrl_rd;
  logic [31:0]        ram_rdata;

  logic bus_up, hit, csr_sel, mem_sel, csr_mapped, enter_ack;
  logic ctrl_wr, cnt_clr, status_clr, wrap_evt;
  logic [1:0] csr_idx;

  assign bus_up     = wbs_cyc_i & wbs_stb_i;
  assign hit        = bus_up & ((wbs_adr_i & BASE_MASK) == BASE_ADDR);
  assign csr_sel    = wbs_adr_i[CSR_SEL_BIT];
  assign mem_sel    = !csr_sel && (wbs_adr_i[CSR_SEL_BIT-1:AW+2] == '0);
  assign csr_mapped = csr_sel && (wbs_adr_i[CSR_SEL_BIT-1:4] == '0);
  assign csr_idx    = wbs_adr_i[3:2];

  // All side effects (write commit, read capture) happen on the edge entering ACK.
  assign enter_ack = ((state == ST_IDLE) && hit && (delay == '0)) ||
                     ((state == ST_WAIT) && bus_up && (wcnt == DELAY_W'(1)));

  assign ctrl_wr    = enter_ack & wbs_we_i & csr_mapped & (csr_idx == CSR_CTRL);
  assign cnt_clr    = ctrl_wr & wbs_dat_i[CTRL_CLR_BIT];
  assign status_clr = enter_ack & wbs_we_i & csr_mapped & (csr_idx == CSR_STATUS) & wbs_dat_i[0];
  assign wrap_evt   = !cnt_clr & cnt_en & (count == '1);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (hit) begin
          wcnt  <= delay;
          state <= (delay == '0) ? ST_ACK : ST_WAIT;
        end
        ST_WAIT: begin
          if (!bus_up)                       state <= ST_IDLE;
          else if (wcnt == DELAY_W'(1))      state <= ST_ACK;
          else                               wcnt  <= wcnt - DELAY_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_rd                  = '0;
    ctrl_rd[DELAY_W-1:0]     = delay;
    ctrl_rd[CTRL_EN_BIT]     = cnt_en;
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_idx)
      CSR_CTRL:   csr_rdata = ctrl_rd;
      CSR_COUNT:  csr_rdata = 32'(count);
      CSR_STATUS: csr_rdata = {31'b0, wrap};
      default:    csr_rdata = xfers;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      delay    <= DELAY_W'(RST_DELAY);
      cnt_en   <= 1'b0;
      count    <= '0;
      wrap     <= 1'b0;
      xfers    <= '0;
      rd_mem_q <= 1'b0;
      csr_q    <= '0;
    end else begin
      if (ctrl_wr) begin
        delay  <= wbs_dat_i[DELAY_W-1:0];
        cnt_en <= wbs_dat_i[CTRL_EN_BIT];
      end
      if (cnt_clr)     count <= '0;
      else if (cnt_en) count <= count + 1'b1;
      // a wrap on the same edge as a STATUS clear keeps the flag set
      wrap <= wrap_evt | (wrap & !status_clr);
      if (state == ST_ACK) xfers <= xfers + 32'd1;
      if (enter_ack) begin
        rd_mem_q <= mem_sel & !wbs_we_i;
        csr_q    <= (csr_mapped & !wbs_we_i) ? csr_rdata : '0;
      end
    end
  end

  wb_wait_mem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (wb_clk_i),
    .en    (enter_ack & mem_sel),
    .we    (wbs_we_i),
    .sel   (wbs_sel_i),
    .addr  (wbs_adr_i[AW+1:2]),
    .wdata (wbs_dat_i),
    .rdata (ram_rdata)
  );

  assign wbs_ack_o = (state == ST_ACK);
  assign wbs_dat_o = wbs_ack_o ? (rd_mem_q ? ram_rdata : csr_q) : '0;
  assign count_o   = count;
  assign irq_o     = wrap;

endmodule

// File: tb/tb_wb_wait_mem.sv
// Directed bench for wb_wait_mem: driver pushes expected ack cycle and read data, a monitor checks each ack.
module tb_wb_wait_mem;

  localparam logic [31:0] BASE  = 32'h3800_0000;
  localparam logic [31:0] CSRB  = 32'h3808_0000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  count_o;
  logic        irq_o;

  wb_wait_mem #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .count_o    (count_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  int unsigned cycle = 0;
  int          ack_cnt = 0;
  int          xfers_model = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ack) begin
      ack_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_cycle", cycle, e.cyc);
        if (e.chk) chk("rd_data", rdat, e.data);
      end
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic c, input logic [31:0] x, input int dly);
    int n;
    @(posedge clk); #1;
    sb.push_back('{chk: c, data: x, cyc: cycle + dly + 1});
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 400);
    if (!ack) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    xfers_model++;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input int dly);
    xfer(1'b1, a, s, d, 1'b0, 32'h0, dly);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] x, input int dly);
    xfer(1'b0, a, 4'hF, 32'h0, 1'b1, x, dly);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks_before;
    logic ack_seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_count", {24'b0, count_o}, 32'd0);
    chk("rst_irq", {31'b0, irq_o}, 32'd0);
    rst_n = 1'b1;

    // reset delay is 10 -> ack 11 cycles after hit
    rd(CSRB + 32'h0, 32'd10, 10);
    wr(CSRB + 32'h0, 4'hF, 32'h0, 10);

    // delay 0
    wr(BASE + 32'h40, 4'hF, 32'hDEAD_BEEF, 0);
    rd(BASE + 32'h40, 32'hDEAD_BEEF, 0);

    // byte lanes, delay 3 applied from next transaction
    wr(BASE + 32'h0, 4'hF, 32'hAABB_CCDD, 0);
    wr(CSRB + 32'h0, 4'hF, 32'd3, 0);
    wr(BASE + 32'h0, 4'b0101, 32'h1122_3344, 3);
    rd(BASE + 32'h0, 32'hAA22_CC44, 3);

    // abort during wait states
    wr(BASE + 32'h10, 4'hF, 32'h5555_AAAA, 3);
    wr(CSRB + 32'h0, 4'hF, 32'd10, 3);
    acks_before = ack_cnt;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h10; dat = 32'hFFFF_FFFF;
    repeat (5) @(posedge clk);
    #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_no_ack", ack_cnt, acks_before);
    rd(BASE + 32'h10, 32'h5555_AAAA, 10);

    // unmapped regions and transfer count
    wr(CSRB + 32'h0, 4'hF, 32'd0, 10);
    rd(BASE + DEPTH * 4, 32'h0, 0);
    rd(CSRB + 32'd20, 32'h0, 0);
    rd(CSRB + 32'hC, xfers_model, 0);
    rd(CSRB + 32'h4, 32'h0, 0);

    // counter wrap, clear, clear-vs-wrap
    wr(CSRB + 32'h0, 4'hF, 32'h0003_0000, 0);
    chk("irq_before_wrap", {31'b0, irq_o}, 32'd0);
    n = 0;
    while (count_o != 8'd255 && n < 600) begin @(negedge clk); n++; end
    if (count_o != 8'd255) chk("wait_255_timeout", {24'b0, count_o}, 32'd255);
    @(negedge clk);
    chk("wrap_count", {24'b0, count_o}, 32'd0);
    chk("wrap_irq", {31'b0, irq_o}, 32'd1);
    wr(CSRB + 32'h8, 4'hF, 32'd1, 0);
    chk("irq_cleared", {31'b0, irq_o}, 32'd0);
    rd(CSRB + 32'h8, 32'd0, 0);
    n = 0;
    while (count_o != 8'd254 && n < 600) begin @(negedge clk); n++; end
    if (count_o != 8'd254) chk("wait_254_timeout", {24'b0, count_o}, 32'd254);
    wr(CSRB + 32'h8, 4'hF, 32'd1, 0);
    chk("irq_set_wins", {31'b0, irq_o}, 32'd1);

    // reset during wait states
    wr(CSRB + 32'h0, 4'hF, 32'h0001_0003, 0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h40; dat = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    ack_seen = 1'b0;
    repeat (6) begin
      #1 ack_seen = ack_seen | ack;
      @(negedge clk);
    end
    chk("rst_mid_ack", {31'b0, ack_seen}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfers_model = 0;
    chk("rst2_count", {24'b0, count_o}, 32'd0);
    chk("rst2_irq", {31'b0, irq_o}, 32'd0);
    rd(CSRB + 32'h0, 32'd10, 10);
    rd(BASE + 32'h40, 32'hDEAD_BEEF, 10);
    rd(CSRB + 32'hC, xfers_model, 10);

    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0) chk("sb_drain", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
